// File: rtl/f2_vga_timing.sv
// VGA raster timing: pixel-rate counters, registered sync/colour outputs and a
// frame marker, clocked at twice the pixel rate with a toggling pixel enable.
module f2_vga_timing #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [2:0]  display_data,
  output logic [21:0] display_addr,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [2:0]  vga_rgb,
  output logic        pixel_tick,
  output logic        frame_start
);

  logic        tick_reg;
  logic [10:0] h_count_reg, h_count_next;
  logic [10:0] v_count_reg, v_count_next;
  logic        hsync_reg, vsync_reg;
  logic [2:0]  rgb_reg;
  logic        h_last, v_last, active;

  // ">=" rather than "==" so an out-of-range count recovers on the next tick
  assign h_last = h_count_reg >= 11'(H_TOTAL - 1);
  assign v_last = v_count_reg >= 11'(V_TOTAL - 1);
  assign active = (h_count_reg >= 11'(H_ACT_START)) && (h_count_reg <= 11'(H_ACT_END)) &&
                  (v_count_reg >= 11'(V_ACT_START)) && (v_count_reg <= 11'(V_ACT_END));

  always_comb begin
    h_count_next = h_count_reg + 11'd1;
    v_count_next = v_count_reg;
    if (h_last) begin
      h_count_next = 11'd0;
      v_count_next = v_last ? 11'd0 : v_count_reg + 11'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg    <= 1'b0;
      h_count_reg <= 11'd0;
      v_count_reg <= 11'd0;
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      rgb_reg     <= 3'b000;
    end else begin
      tick_reg <= ~tick_reg;
      if (tick_reg) begin
        h_count_reg <= h_count_next;
        v_count_reg <= v_count_next;
        hsync_reg   <= ~(h_count_reg < 11'(H_SYNC));
        vsync_reg   <= ~(v_count_reg < 11'(V_SYNC));
        rgb_reg     <= active ? display_data : 3'b000;
      end
    end
  end

  // Gated by the tick so the pulse is one sysclk wide and vanishes with reset
  assign frame_start  = tick_reg && h_last && v_last;
  assign pixel_tick   = tick_reg;
  assign display_addr = {h_count_reg, v_count_reg};
  assign vga_hsync    = hsync_reg;
  assign vga_vsync    = vsync_reg;
  assign vga_rgb      = rgb_reg;

endmodule
